switch_conditioner: RTL

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/switch_conditioner_pkg.sv | 15 +
 rtl/debounce_channel.sv | 87 ++++++++
 rtl/switch_conditioner.sv | 29 ++
 3 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared types and defaults for the switch conditioner: debounce FSM encoding
// and the default debounce interval.
package switch_conditioner_pkg;

  // 10 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, debounce FSM with mismatch counter,
// registered level and one-cycle rise/fall pulses.
module debounce_channel
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          synced;
  db_state_e     state;
  logic [CW-1:0] cnt;

  assign synced = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw};
  end

  // The counter tops out at DEBOUNCE_CYCLES-1, where the WAIT state always
  // either commits or aborts, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: if (synced) begin
          state <= WAIT_HI;
          cnt   <= CNT_ONE;
        end
        WAIT_HI: begin
          if (!synced) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: if (!synced) begin
          state <= WAIT_LO;
          cnt   <= CNT_ONE;
        end
        WAIT_LO: begin
          if (synced) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces N_CH independent board switches; each channel is a debounce_channel.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_level,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .level(sw_level[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule
